cfi_shadow_stack: RTL and testbench
===================================

Name: cfi_shadow_stack

Overview:
- Hardware shadow-stack responder that executes the CFI shadow-stack instructions: sspush (x1/x5), sspop, sspopchk (x1/x5) and ssprr.
- Issue logic acts as initiator. It sends one decoded operation at a time. This block updates an on-chip return-address stack and returns a result or a CFI exception.
- Sits beside the CSR/commit path. Ops are issued non-speculatively at commit.

Parameters:
- XLEN, 64, width of return addresses and of the result.
- DEPTH, 16, number of stack entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer; counts 0..DEPTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  shadow stack enabled (from CSR)
- flush_i  in  1  drop the pending response
- req_valid_i  in  1  operation valid
- req_ready_o  out  1  block can accept an operation
- req_op_i  in  2  operation: 0 PUSH, 1 POP, 2 POPCHK, 3 RDPTR
- req_data_i  in  XLEN  x1/x5 value for PUSH and POPCHK
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  initiator accepts the response
- resp_data_o  out  XLEN  POP: popped value; RDPTR: zero-extended pointer; otherwise 0
- resp_ex_o  out  1  exception raised
- resp_cause_o  out  2  exception cause: 0 none, 1 overflow, 2 underflow, 3 popchk mismatch
- ssp_o  out  PTR_W  current stack pointer (number of valid entries)

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state IDLE, ssp=0, resp_valid_o=0, resp_data_o=0, resp_ex_o=0, resp_cause_o=0.
  - Stack array contents are don't-care and need not be reset.
- State machine:
  - IDLE: req_ready_o=1. Accept when req_valid_i is high, then go to RESP.
  - RESP: req_ready_o=0. Hold resp_* stable until resp_ready_i is high, then return to IDLE.
  - Back-to-back throughput is one op per 2 cycles. No bypass.
- Latency: an op accepted at edge N has its response visible from N+1.
- Stack and ssp updates happen at the accept edge, never later.
- PUSH:
  - If ssp<DEPTH: write mem[ssp]=req_data_i, ssp+1, no exception.
  - If ssp==DEPTH: no write, ssp unchanged, ex=1, cause=1.
- POP:
  - If ssp>0: resp_data = mem[ssp-1], ssp-1.
  - If ssp==0: ex=1, cause=2, data 0, ssp unchanged.
- POPCHK:
  - ssp==0: ex=1, cause=2.
  - mem[ssp-1]==req_data_i: ssp-1, no exception.
  - Mismatch: ex=1, cause=3, ssp unchanged. The entry is retained for software diagnosis.
- RDPTR: resp_data = {zeros, ssp}. Never raises an exception. Valid even when en_i=0.
- en_i=0: PUSH, POP and POPCHK are NOPs. Response is given with ex=0 and data 0, ssp unchanged.
- en_i is sampled at the accept edge only.
- flush_i:
  - In RESP: return to IDLE next edge and deassert resp_valid_o. The stack update already done is NOT undone, since ops are committed.
  - In IDLE: any request presented in the same cycle is ignored. Flush has priority over accept.
- flush_i together with resp_ready_i: flush wins; the result is the same.
- Pointer never wraps. Range is 0..DEPTH inclusive, enforced by the overflow and underflow checks.
- Reset mid-operation: a pending response is lost and ssp returns to 0.
- ssp_o is a registered copy of the internal pointer; it reflects the update from the cycle after accept.

Test Plan:
- Push 0x8000_1000, then POPCHK with 0x8000_1000: both responses ex=0; ssp goes 1 then 0; resp_valid_o rises exactly one cycle after each accept.
- Push 0x8000_2000, then POPCHK with 0x8000_2004: ex=1, cause=3, ssp stays 1; a following POP returns 0x8000_2000 with ssp=0.
- DEPTH=16: pushes 0x100+i for i=0..15 succeed. The 17th push gives ex=1, cause=1, ssp=16. Sixteen POPs return 0x10F down to 0x100. The 17th POP gives ex=1, cause=2.
- Hold resp_ready_i low for 5 cycles after a push: resp_* stay stable, req_ready_o=0, and a second req_valid_i is not accepted until the handshake completes.
- en_i=0: PUSH 0xDEAD gives ex=0 and ssp stays 0. RDPTR gives data 0. Set en_i=1, PUSH, then RDPTR gives data 1.
- Flush after a PUSH is accepted (state RESP): resp_valid_o drops next cycle and ssp stays 1. Assert rst_ni low mid-RESP: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/cfi_shadow_stack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cfi_shadow_stack
// Description : CFI shadow-stack responder. Executes sspush, sspop, sspopchk
//               and ssprr one at a time against an on-chip return-address
//               stack, answering with a result or a CFI exception cause.
// Revision    : 1.0 - initial release
// ============================================================================
module cfi_shadow_stack #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_data_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_data_o,
    output logic             resp_ex_o,
    output logic [1:0]       resp_cause_o,
    output logic [PTR_W-1:0] ssp_o
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [1:0] c_OP_PUSH  = 2'd0;
    localparam logic [1:0] c_OP_POP   = 2'd1;
    localparam logic [1:0] c_OP_CHK   = 2'd2;
    localparam logic [1:0] c_CAUSE_NO = 2'd0;
    localparam logic [1:0] c_CAUSE_OV = 2'd1;
    localparam logic [1:0] c_CAUSE_UN = 2'd2;
    localparam logic [1:0] c_CAUSE_MM = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_ssp;
    logic [XLEN-1:0]  r_resp_data;
    logic             r_resp_ex;
    logic [1:0]       r_resp_cause;

    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_top_idx;
    logic [XLEN-1:0]  w_top;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_ssp_nxt;
    logic [XLEN-1:0]  w_data;
    logic             w_ex;
    logic [1:0]       w_cause;

    // Flush in IDLE suppresses any request presented in the same cycle.
    assign w_accept  = (r_state == S_IDLE) && req_valid_i && !flush_i;
    assign w_full    = (r_ssp == PTR_W'(DEPTH));
    assign w_empty   = (r_ssp == '0);
    assign w_top_idx = IDX_W'(r_ssp - PTR_W'(1));
    assign w_top     = r_mem[w_top_idx];

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (w_accept) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (flush_i || resp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Decode the operation into a stack update and a response word.
    always_comb begin
        w_wr_en   = 1'b0;
        w_ssp_nxt = r_ssp;
        w_data    = '0;
        w_ex      = 1'b0;
        w_cause   = c_CAUSE_NO;
        if (req_op_i == 2'd3) begin
            // Pointer read works regardless of the enable.
            w_data = {{(XLEN-PTR_W){1'b0}}, r_ssp};
        end else if (en_i) begin
            case (req_op_i)
                c_OP_PUSH: begin
                    if (w_full) begin
                        w_ex    = 1'b1;
                        w_cause = c_CAUSE_OV;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_ssp_nxt = r_ssp + PTR_W'(1);
                    end
                end
                c_OP_POP: begin
                    if (w_empty) begin
                        w_ex    = 1'b1;
                        w_cause = c_CAUSE_UN;
                    end else begin
                        w_data    = w_top;
                        w_ssp_nxt = r_ssp - PTR_W'(1);
                    end
                end
                c_OP_CHK: begin
                    if (w_empty) begin
                        w_ex    = 1'b1;
                        w_cause = c_CAUSE_UN;
                    end else if (w_top == req_data_i) begin
                        w_ssp_nxt = r_ssp - PTR_W'(1);
                    end else begin
                        // Mismatching entry is kept so software can inspect it.
                        w_ex    = 1'b1;
                        w_cause = c_CAUSE_MM;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register, pointer and response registers; all commit at accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_ssp        <= '0;
            r_resp_data  <= '0;
            r_resp_ex    <= 1'b0;
            r_resp_cause <= c_CAUSE_NO;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ssp        <= w_ssp_nxt;
                r_resp_data  <= w_data;
                r_resp_ex    <= w_ex;
                r_resp_cause <= w_cause;
            end else if (r_state == S_RESP && (flush_i || resp_ready_i)) begin
                // Clear the response word once it is consumed or dropped.
                r_resp_data  <= '0;
                r_resp_ex    <= 1'b0;
                r_resp_cause <= c_CAUSE_NO;
            end
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_wr_en) r_mem[r_ssp[IDX_W-1:0]] <= req_data_i;
    end

    assign resp_data_o  = r_resp_data;
    assign resp_ex_o    = r_resp_ex;
    assign resp_cause_o = r_resp_cause;
    assign ssp_o        = r_ssp;

endmodule
`default_nettype wire

// File: tb/tb_cfi_shadow_stack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cfi_shadow_stack
// Description : Directed self-checking bench for cfi_shadow_stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfi_shadow_stack;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             en_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [1:0]       req_op_i = 2'd0;
    logic [XLEN-1:0]  req_data_i = '0;
    logic             resp_valid_o;
    logic             resp_ready_i = 1'b0;
    logic [XLEN-1:0]  resp_data_o;
    logic             resp_ex_o;
    logic [1:0]       resp_cause_o;
    logic [PTR_W-1:0] ssp_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    cfi_shadow_stack #(.XLEN(XLEN), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_data_i   (req_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_ex_o    (resp_ex_o),
        .resp_cause_o (resp_cause_o),
        .ssp_o        (ssp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one op; check the response appears on the edge after accept.
    task automatic issue(input logic [1:0] op, input logic [63:0] data,
                         input logic [63:0] e_data, input logic e_ex,
                         input logic [1:0] e_cause, input int e_ssp);
        @(negedge clk_i);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_data_i  = data;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("resp_valid", resp_valid_o, 1);
        chk("resp_data", resp_data_o, e_data);
        chk("resp_ex", resp_ex_o, e_ex);
        chk("resp_cause", resp_cause_o, e_cause);
        chk("ssp", ssp_o, e_ssp);
    endtask

    task automatic complete();
        @(negedge clk_i);
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b0;
        chk("resp_valid_done", resp_valid_o, 0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [63:0] data,
                         input logic [63:0] e_data, input logic e_ex,
                         input logic [1:0] e_cause, input int e_ssp);
        issue(op, data, e_data, e_ex, e_cause, e_ssp);
        complete();
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        chk("rst_resp_ex", resp_ex_o, 0);
        chk("rst_resp_cause", resp_cause_o, 0);
        chk("rst_ssp", ssp_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Push then matching POPCHK
        do_op(2'd0, 64'h8000_1000, 0, 0, 0, 1);
        do_op(2'd2, 64'h8000_1000, 0, 0, 0, 0);

        // POPCHK mismatch keeps the entry; POP then retrieves it
        do_op(2'd0, 64'h8000_2000, 0, 0, 0, 1);
        do_op(2'd2, 64'h8000_2004, 0, 1, 3, 1);
        do_op(2'd1, 0, 64'h8000_2000, 0, 0, 0);

        // Fill to DEPTH, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++)
            do_op(2'd0, 64'h100 + 64'(i), 0, 0, 0, i + 1);
        do_op(2'd0, 64'h999, 0, 1, 1, DEPTH);
        for (int i = 0; i < DEPTH; i++)
            do_op(2'd1, 0, 64'h10F - 64'(i), 0, 0, DEPTH - 1 - i);
        do_op(2'd1, 0, 0, 1, 2, 0);
        do_op(2'd2, 64'h1, 0, 1, 2, 0);

        // Response held under back-pressure; second request not accepted
        issue(2'd0, 64'hABC, 0, 0, 0, 1);
        req_valid_i = 1'b1;
        req_op_i    = 2'd0;
        req_data_i  = 64'h555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            chk("hold_valid", resp_valid_o, 1);
            chk("hold_ready", req_ready_o, 0);
            chk("hold_ex", resp_ex_o, 0);
            chk("hold_ssp", ssp_o, 1);
        end
        req_valid_i = 1'b0;
        complete();
        do_op(2'd1, 0, 64'hABC, 0, 0, 0);

        // Disabled stack: ops are NOPs, RDPTR still works
        en_i = 1'b0;
        do_op(2'd0, 64'hDEAD, 0, 0, 0, 0);
        do_op(2'd1, 0, 0, 0, 0, 0);
        do_op(2'd3, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        en_i = 1'b1;
        do_op(2'd0, 64'h55, 0, 0, 0, 1);
        do_op(2'd3, 0, 64'h1, 0, 0, 1);

        // Flush in RESP drops the response but keeps the stack update
        issue(2'd0, 64'h77, 0, 0, 0, 2);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("flush_resp_valid", resp_valid_o, 0);
        chk("flush_ssp", ssp_o, 2);
        // Flush in IDLE wins over a simultaneous request
        req_valid_i = 1'b1;
        req_op_i    = 2'd0;
        req_data_i  = 64'h88;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("flush_idle_valid", resp_valid_o, 0);
        chk("flush_idle_ssp", ssp_o, 2);
        do_op(2'd1, 0, 64'h77, 0, 0, 1);

        // Asynchronous reset while a response is pending
        issue(2'd1, 0, 64'h55, 0, 0, 0);
        issue_dummy_wait();
        do_op(2'd0, 64'h42, 0, 0, 0, 1);
        issue(2'd3, 0, 64'h1, 0, 0, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid_o, 0);
        chk("arst_resp_data", resp_data_o, 0);
        chk("arst_resp_ex", resp_ex_o, 0);
        chk("arst_resp_cause", resp_cause_o, 0);
        chk("arst_ssp", ssp_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_op(2'd3, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Finish the outstanding POP response from the previous issue.
    task automatic issue_dummy_wait();
        complete();
    endtask

    // Safety net against a hung handshake.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
